// File: rtl/i2c_slave_responder.sv
// I2C slave exposing four 8-bit registers: pointer write, auto-increment data write, sequential read.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through an active-low enable.
module i2c_slave_responder #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
   parameter int unsigned GLITCH_SYNC = 2
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_o,
   output logic        sda_en_o,
   output logic [31:0] regs_o,
   output logic        busy_o
);

   localparam int unsigned SYNC_W = (GLITCH_SYNC < 2) ? 2 : GLITCH_SYNC;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE
   } state_t;

   state_t            state_q, state_d;
   logic [SYNC_W-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_W-1:0] sda_sync_q, sda_sync_d;
   logic              scl_prev_q, scl_prev_d;
   logic              sda_prev_q, sda_prev_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shreg_q, shreg_d;
   logic [1:0]        ptr_q, ptr_d;
   logic              rw_q, rw_d;
   logic [3:0][7:0]   regs_q, regs_d;
   logic              sda_en_q, sda_en_d;
   logic              busy_q, busy_d;

   logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
   logic [7:0] rx_byte;

   assign scl_s    = scl_sync_q[SYNC_W-1];
   assign sda_s    = sda_sync_q[SYNC_W-1];
   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   // SCL must be high in both samples so an SCL edge coinciding with an SDA edge is not a condition
   assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign rx_byte  = {shreg_q[6:0], sda_s};

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_W-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_W-2:0], sda_i};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      ptr_d      = ptr_q;
      rw_d       = rw_q;
      regs_d     = regs_q;
      sda_en_d   = sda_en_q;
      busy_d     = busy_q;

      case (state_q)
         ADDR: begin
            if (scl_rise) begin
               shreg_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                     state_d = ADDR_ACK;
                     rw_d    = rx_byte[0];
                     busy_d  = 1'b1;
                  end else begin
                     state_d = IGNORE;
                     busy_d  = 1'b0;
                  end
               end
            end
         end
         PTR, WRITE: begin
            if (scl_rise) begin
               shreg_d   = rx_byte;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  if (state_q == PTR) begin
                     ptr_d   = rx_byte[1:0];
                     state_d = PTR_ACK;
                  end else begin
                     regs_d[ptr_q] = rx_byte;
                     ptr_d         = ptr_q + 2'd1;
                     state_d       = WR_ACK;
                  end
               end
            end
         end
         // count 8: ACK goes out at the 8th falling edge; count 9: released at the 9th
         ADDR_ACK, PTR_ACK, WR_ACK: begin
            if (scl_fall) begin
               if (bit_cnt_q == 4'd8) begin
                  sda_en_d  = 1'b0;
                  bit_cnt_d = 4'd9;
               end else if (bit_cnt_q == 4'd9) begin
                  sda_en_d  = 1'b1;
                  bit_cnt_d = 4'd0;
                  if (state_q == ADDR_ACK && rw_q) begin
                     state_d  = READ;
                     shreg_d  = regs_q[ptr_q];
                     sda_en_d = regs_q[ptr_q][7];
                  end else if (state_q == ADDR_ACK) begin
                     state_d = PTR;
                  end else begin
                     state_d = WRITE;
                  end
               end
            end
         end
         READ: begin
            if (scl_rise && bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
            if (scl_fall) begin
               if (bit_cnt_q == 4'd8) begin
                  sda_en_d = 1'b1;
                  state_d  = RD_ACK;
               end else if (bit_cnt_q != 4'd0) begin
                  shreg_d  = {shreg_q[6:0], 1'b0};
                  sda_en_d = shreg_q[6];
               end
            end
         end
         RD_ACK: begin
            if (scl_rise && bit_cnt_q == 4'd8) begin
               if (sda_s) begin
                  state_d = IGNORE;
               end else begin
                  ptr_d     = ptr_q + 2'd1;
                  bit_cnt_d = 4'd9;
               end
            end else if (scl_fall && bit_cnt_q == 4'd9) begin
               state_d   = READ;
               bit_cnt_d = 4'd0;
               shreg_d   = regs_q[ptr_q];
               sda_en_d  = regs_q[ptr_q][7];
            end
         end
         default: ;
      endcase

      // STOP is applied last so it wins over a simultaneous START
      if (start_c) begin
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         sda_en_d  = 1'b1;
      end
      if (stop_c) begin
         state_d   = IDLE;
         bit_cnt_d = 4'd0;
         sda_en_d  = 1'b1;
         busy_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q    <= IDLE;
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         bit_cnt_q  <= 4'd0;
         shreg_q    <= 8'h00;
         ptr_q      <= 2'd0;
         rw_q       <= 1'b0;
         regs_q     <= '0;
         sda_en_q   <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         ptr_q      <= ptr_d;
         rw_q       <= rw_d;
         regs_q     <= regs_d;
         sda_en_q   <= sda_en_d;
         busy_q     <= busy_d;
      end
   end

   assign sda_o    = 1'b0;
   assign sda_en_o = sda_en_q;
   assign regs_o   = regs_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, directed vector table,
// reset/no-START corner cases, and randomized transactions against a register-array model.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

   logic        clk = 1'b0;
   logic        arst, scl, m_sda, sda_line, sda_o, sda_en, busy;
   logic [31:0] regs;
   logic        jit;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  mem [4];

   // open-drain bus: either side may pull low
   assign sda_line = m_sda & sda_en;
   always #5 clk = ~clk;

   i2c_slave_responder #(.SLAVE_ADDR(7'h50), .GLITCH_SYNC(2)) dut (
      .clk(clk), .arst(arst), .scl_i(scl), .sda_i(sda_line),
      .sda_o(sda_o), .sda_en_o(sda_en), .regs_o(regs), .busy_o(busy));

   typedef struct {
      logic [6:0]  a;
      logic        rd;
      logic [1:0]  p;
      logic [5:0]  hi;
      int          n;
      logic [31:0] wd;
      int          exp_acks;
      logic        exp_busy;
      logic [31:0] exp_rdat;
      logic [31:0] exp_regs;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic dly();
      int unsigned d;
      d = 50 + (jit ? $urandom_range(0, 9) : 0);
      #(d);
   endtask

   task automatic send_bit(input logic b);
      dly(); m_sda = b;
      dly(); scl = 1'b1;
      dly(); dly(); scl = 1'b0;
   endtask

   task automatic recv_bit(output logic b);
      dly(); m_sda = 1'b1;
      dly(); scl = 1'b1;
      dly(); b = sda_line;
      dly(); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      recv_bit(r);
      ack = ~r;
   endtask

   task automatic recv_byte(output logic [7:0] b, input logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(r);
         b[i] = r;
      end
      send_bit(~ack);
   endtask

   task automatic i2c_start();
      dly(); m_sda = 1'b1;
      dly(); scl = 1'b1;
      dly(); m_sda = 1'b0;
      dly(); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      dly(); m_sda = 1'b0;
      dly(); scl = 1'b1;
      dly(); m_sda = 1'b1;
      dly();
   endtask

   task automatic txn(input logic [6:0] a, input logic rd, input logic [1:0] p, input logic [5:0] hi,
                      input int n, input logic [31:0] wd, output int acks, output logic busy_mid,
                      output logic [31:0] rdat, output logic rel_ok);
      logic       ack;
      logic [7:0] b;
      acks = 0; rdat = '0; rel_ok = 1'b1;
      i2c_start();
      send_byte({a, 1'b0}, ack);
      busy_mid = busy;
      if (ack) begin
         acks++;
         send_byte({hi, p}, ack);
         if (ack) acks++;
         if (!rd) begin
            for (int i = 0; i < n; i++) begin
               send_byte(wd[8*i +: 8], ack);
               if (ack) acks++;
            end
         end else begin
            i2c_start();
            send_byte({a, 1'b1}, ack);
            if (ack) acks++;
            for (int i = 0; i < n; i++) begin
               recv_byte(b, i < n - 1);
               rdat[8*i +: 8] = b;
            end
            dly();
            rel_ok = sda_en;
         end
      end
      i2c_stop();
   endtask

   // reference: address match gates everything; bytes land at successive pointer values mod 4
   task automatic model(input logic [6:0] a, input logic rd, input logic [1:0] p, input int n,
                        input logic [31:0] wd, output int acks, output logic [31:0] rdat);
      acks = 0; rdat = '0;
      if (a != 7'h50) return;
      if (rd) begin
         acks = 3;
         for (int i = 0; i < n; i++) rdat[8*i +: 8] = mem[2'((int'(p) + i) % 4)];
      end else begin
         acks = 2 + n;
         for (int i = 0; i < n; i++) mem[2'((int'(p) + i) % 4)] = wd[8*i +: 8];
      end
   endtask

   function automatic logic [31:0] model_regs();
      return {mem[3], mem[2], mem[1], mem[0]};
   endfunction

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [4];
      int          acks, macks;
      logic        bmid, rel, ack;
      logic [31:0] rdat, mrdat;
      logic [7:0]  dbyte;
      logic [6:0]  a;
      logic        rd;
      logic [1:0]  p;
      int          n;
      logic [31:0] wd;

      tbl[0] = '{7'h50, 1'b0, 2'd1, 6'h00, 2, 32'h0000_5A3C, 4, 1'b1, 32'h0, 32'h005A_3C00};
      tbl[1] = '{7'h50, 1'b0, 2'd3, 6'h3F, 2, 32'h0000_2211, 4, 1'b1, 32'h0, 32'h115A_3C22};
      tbl[2] = '{7'h50, 1'b1, 2'd2, 6'h15, 2, 32'h0,         3, 1'b1, 32'h0000_115A, 32'h115A_3C22};
      tbl[3] = '{7'h58, 1'b0, 2'd0, 6'h00, 1, 32'h0000_00FF, 0, 1'b0, 32'h0, 32'h115A_3C22};

      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      jit = 1'b0; scl = 1'b1; m_sda = 1'b1; arst = 1'b1;
      #3 arst = 1'b0;
      #10;
      check("rst_regs", regs, 32'h0);
      check("rst_sda_en", 32'(sda_en), 32'h1);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_sda_o", 32'(sda_o), 32'h0);
      #20 arst = 1'b1;
      #40;

      for (int k = 0; k < 4; k++) begin
         model(tbl[k].a, tbl[k].rd, tbl[k].p, tbl[k].n, tbl[k].wd, macks, mrdat);
         txn(tbl[k].a, tbl[k].rd, tbl[k].p, tbl[k].hi, tbl[k].n, tbl[k].wd, acks, bmid, rdat, rel);
         check($sformatf("vec%0d_acks", k), 32'(acks), 32'(tbl[k].exp_acks));
         check($sformatf("vec%0d_busy_mid", k), 32'(bmid), 32'(tbl[k].exp_busy));
         check($sformatf("vec%0d_regs", k), regs, tbl[k].exp_regs);
         check($sformatf("vec%0d_busy_end", k), 32'(busy), 32'h0);
         if (tbl[k].rd) begin
            check($sformatf("vec%0d_rdata", k), rdat, tbl[k].exp_rdat);
            check($sformatf("vec%0d_released", k), 32'(rel), 32'h1);
         end
      end

      // reset during the 5th data bit of a write
      dbyte = 8'hC5;
      i2c_start();
      send_byte(8'hA0, ack);
      send_byte(8'h00, ack);
      for (int i = 7; i > 3; i--) send_bit(dbyte[i]);
      dly(); m_sda = dbyte[3];
      dly(); scl = 1'b1;
      #20 arst = 1'b0;
      #1;
      check("midrst_regs", regs, 32'h0);
      check("midrst_sda_en", 32'(sda_en), 32'h1);
      check("midrst_busy", 32'(busy), 32'h0);
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      m_sda = 1'b1;
      #100 arst = 1'b1;
      #100;

      // clocking an address without a START must not be answered
      dly(); scl = 1'b0;
      send_byte(8'hA0, ack);
      check("nostart_ack", 32'(ack), 32'h0);
      check("nostart_busy", 32'(busy), 32'h0);
      i2c_stop();

      txn(7'h50, 1'b0, 2'd1, 6'h00, 2, 32'h0000_5A3C, acks, bmid, rdat, rel);
      model(7'h50, 1'b0, 2'd1, 2, 32'h0000_5A3C, macks, mrdat);
      check("postrst_acks", 32'(acks), 32'd4);
      check("postrst_regs", regs, 32'h005A_3C00);

      // same write with line edges at arbitrary clk phase, from a fresh reset
      arst = 1'b0;
      #30 arst = 1'b1;
      for (int i = 0; i < 4; i++) mem[i] = 8'h00;
      #50;
      jit = 1'b1;
      txn(7'h50, 1'b0, 2'd1, 6'h00, 2, 32'h0000_5A3C, acks, bmid, rdat, rel);
      model(7'h50, 1'b0, 2'd1, 2, 32'h0000_5A3C, macks, mrdat);
      check("jit_acks", 32'(acks), 32'd4);
      check("jit_busy_mid", 32'(bmid), 32'h1);
      check("jit_regs", regs, 32'h005A_3C00);
      check("jit_busy_end", 32'(busy), 32'h0);

      for (int k = 0; k < 24; k++) begin
         a  = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h50;
         rd = 1'($urandom_range(0, 1));
         p  = 2'($urandom);
         n  = $urandom_range(1, 4);
         wd = $urandom;
         model(a, rd, p, n, wd, macks, mrdat);
         txn(a, rd, p, 6'($urandom), n, wd, acks, bmid, rdat, rel);
         check($sformatf("rnd%0d_acks", k), 32'(acks), 32'(macks));
         check($sformatf("rnd%0d_busy_mid", k), 32'(bmid), 32'(a == 7'h50));
         check($sformatf("rnd%0d_rdata", k), rdat, mrdat);
         check($sformatf("rnd%0d_regs", k), regs, model_regs());
         check($sformatf("rnd%0d_busy_end", k), 32'(busy), 32'h0);
         if (rd && a == 7'h50) check($sformatf("rnd%0d_released", k), 32'(rel), 32'h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, 7-bit bus address the block answers to.
REQ-002 SHALL have parameter GLITCH_SYNC, default 2, number of synchronizer flops on scl_i/sda_i (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all state on posedge clk.
REQ-004 SHALL have port arst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port scl_i  input  1  SCL line input, asynchronous to clk.
REQ-006 SHALL have port sda_i  input  1  SDA line input, asynchronous to clk.
REQ-007 SHALL have port sda_o  output  1  SDA output value, constant 1'b0.
REQ-008 SHALL have port sda_en_o  output  1  SDA output enable, active low (0 = pull SDA low, 1 = release).
REQ-009 SHALL have port regs_o  output  32  register bank {reg3,reg2,reg1,reg0}, 8 bits each.
REQ-010 SHALL have port busy_o  output  1  high from addressed START to STOP.

Function
REQ-011 SHALL synchronize scl_i/sda_i through GLITCH_SYNC flops; all decoding uses synchronized values and their previous-cycle copies.
REQ-012 SHALL detect START as synced SDA 1->0 while synced SCL = 1, and STOP as SDA 0->1 while SCL = 1; both are detected in any state.
REQ-013 SHALL sample SDA on synced SCL rising edge and change sda_en_o only on the cycle after a synced SCL falling edge.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE.
REQ-015 SHALL go from any state to ADDR on START (repeated START included), clearing the bit counter.
REQ-016 SHALL go from any state to IDLE on STOP, release SDA (sda_en_o = 1) and clear busy_o.
REQ-017 ADDR: SHALL shift 8 bits MSB first; on address match go to ADDR_ACK and drive ACK; on mismatch go to IGNORE with SDA released.
REQ-018 ADDR_ACK: SHALL hold sda_en_o = 0 for exactly the 9th SCL clock, then go to PTR if R/W = 0, or to READ with reg[ptr] loaded if R/W = 1.
REQ-019 PTR: SHALL take the received byte's bits [1:0] as the register pointer (bits [7:2] ignored), ACK, then go to WRITE.
REQ-020 WRITE: SHALL write each received byte to reg[ptr] on the 8th SCL rising edge, ACK it, and increment ptr modulo 4 (3 wraps to 0).
REQ-021 READ: SHALL drive reg[ptr] MSB first (sda_en_o = bit value), then release SDA for the 9th clock and sample master ACK in RD_ACK.
REQ-022 RD_ACK: on ACK (SDA = 0) SHALL increment ptr modulo 4 and reload READ; on NACK SHALL go to IGNORE until STOP/START.
REQ-023 IGNORE: SHALL keep SDA released and take no action except START/STOP handling.
REQ-024 SHALL not stretch SCL; there is no SCL output.
REQ-025 SHALL have regs_o reflect register contents directly (zero latency after the write edge).
REQ-026 busy_o SHALL assert on the ADDR_ACK entry and deassert on STOP or address mismatch.
REQ-027 START and STOP detected in the same cycle (both lines toggling) SHALL be treated as STOP.

Reset
REQ-028 arst = 0 SHALL immediately force state IDLE, ptr = 0, all registers 8'h00, sda_en_o = 1, sda_o = 0, busy_o = 0, and synchronizer flops to 1.
REQ-029 Reset mid-transfer SHALL abandon the transfer; after release the block SHALL respond only after a fresh START.

Verification
REQ-030 Write 0xA0, ptr 0x01, data 0x3C, 0x5A, STOP -> ACK on all 4 bytes; regs_o = 32'h005A3C00; busy_o low after STOP.
REQ-031 Write 0xA0, ptr 0x03, data 0x11, 0x22 -> reg3 = 0x11, reg0 = 0x22 (pointer wrap).
REQ-032 Write 0xA0, ptr 0x02, repeated START, 0xA1, read 2 bytes with ACK then NACK -> returns reg2, reg3; SDA released after the NACK.
REQ-033 Address 0xB0 -> no ACK (SDA stays 1 on the 9th clock); registers unchanged; busy_o stays 0.
REQ-034 Assert arst during the 5th data bit of a write -> outputs at reset values immediately; the next full transaction works normally.
REQ-035 Random-delay synchronizer check: scl_i/sda_i edges at arbitrary clk phase (SCL period 20 clk) -> no false START/STOP and identical results to REQ-030.
